fir_to_fixed_pipe: RTL and testbench
====================================

FIR_TO_FIXED_PIPE -- requirements
Module: fir_to_fixed_pipe

Interface
REQ-001 SHALL have parameter FIR_TE_SIZE, default 8: width of signed total exponent.
REQ-002 SHALL have parameter FIR_FRAC_SIZE, default 8: width of mantissa incl. hidden bit, binary point after MSB.
REQ-003 SHALL have parameter FX_M, default 8: integer bits of fixed magnitude.
REQ-004 SHALL have parameter FX_N, default 16: total fixed magnitude bits; fractional bits = FX_N-FX_M.
REQ-005 SHALL have parameter SAT_CNT_W, default 16: saturation counter width.
REQ-006 clk_i  in  1  clock, all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 valid_i  in  1  input beat valid.
REQ-009 ready_o  out  1  block can accept a beat.
REQ-010 fir_i  in  1+FIR_TE_SIZE+FIR_FRAC_SIZE  {sign, te, frac}.
REQ-011 is_zero_i / is_nar_i  in  1 each  special-value tags, qualified by valid_i.
REQ-012 rnd_mode_i  in  1  0 = truncate toward zero, 1 = round-nearest-even; travels with the beat.
REQ-013 valid_o  out  1;  ready_i  in  1  output handshake.
REQ-014 fixed_o  out  1+FX_N  two's-complement fixed, value = fixed_o / 2^(FX_N-FX_M).
REQ-015 ovf_o / nar_o  out  1 each  per-result saturation / NaR flags.
REQ-016 clear_i  in  1;  sat_cnt_o  out  SAT_CNT_W  saturating count of ovf results.

Function
REQ-017 Input magnitude SHALL be frac * 2^(te - (FIR_FRAC_SIZE-1)); sign applied after rounding and saturation.
REQ-018 Stage 1 SHALL shift mantissa into FX_N+2 bit field plus guard, round and sticky bits (sticky = OR of all bits shifted past round), detecting integer overflow from shift amount.
REQ-019 Stage 2 SHALL round per captured rnd_mode, re-check overflow after round carry, saturate, negate if sign=1.
REQ-020 Saturation SHALL be symmetric: magnitude clamped to 2^FX_N-1, negative result -(2^FX_N-1); ovf_o=1 with that beat.
REQ-021 is_nar_i SHALL yield fixed_o = 1 followed by FX_N zeros, nar_o=1, ovf_o=0; is_zero_i SHALL yield 0; NaR has priority over zero.
REQ-022 Magnitude rounding to 0 with sign=1 SHALL output 0 (no negative zero).
REQ-023 Latency SHALL be exactly 2 cycles from accepted beat to valid_o when ready_i held high; throughput 1 beat/cycle.
REQ-024 Stage registers SHALL advance when downstream empty or consumed; ready_o = !s1_valid | (s1 advances); no beat dropped or duplicated; order preserved.
REQ-025 fixed_o, ovf_o, nar_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-026 sat_cnt_o SHALL increment on each handshake (valid_o & ready_i) with ovf_o=1, stick at all-ones; clear_i zeroes it, clear_i with simultaneous increment yields 0.

Reset
REQ-027 On rst_ni low: both stage valids, valid_o, ovf_o, nar_o = 0, fixed_o = 0, sat_cnt_o = 0; ready_o = 1 after release.
REQ-028 Reset mid-stream SHALL discard in-flight beats; first beat after release emerges 2 cycles after acceptance.

Structure
REQ-029 ppu_pkg SHALL hold the rounding-mode enum (RND_TRUNC, RND_RNE) and the NaR fixed constant function of FX_N.
REQ-030 Round/saturate/negate logic SHALL be one sub-module fixed_round_sat, combinational, instantiated in stage 2.
REQ-031 Datapath SHALL be independent of posit N; parameters only as above.

Verification (defaults)
REQ-032 sign0, te=0, frac=0x80, ready_i=1 -> fixed_o=0x00100, valid_o 2 cycles later, ovf_o=0.
REQ-033 sign1, te=1, frac=0xC0 -> fixed_o=0x1FD00 (-3.0).
REQ-034 sign0, te=8, frac=0x80 -> fixed_o=0x0FFFF, ovf_o=1, sat_cnt_o=1; repeat after clear_i -> sat_cnt_o=1.
REQ-035 te=-9, frac=0x80: RNE -> 0, trunc -> 0; te=-9, frac=0xC0: RNE -> 0x00001, trunc -> 0; is_nar_i -> 0x10000, nar_o=1.
REQ-036 4 back-to-back beats, ready_i low 3 cycles -> ready_o low once 2 held, all 4 delivered in order, outputs stable while stalled.
REQ-037 rst_ni low with 2 beats in flight -> valid_o=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and constants for the posit-to-fixed conversion datapath.
// The rounding mode travels with each beat. NaR maps to the most negative fixed code.
package ppu_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    // Callers truncate the result to FX_N+1 bits: only the sign bit is set.
    function automatic logic [63:0] nar_fixed(input int fx_n);
        return 64'd1 << fx_n;
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rounding, symmetric saturation and sign application for stage 2.
// Special tags override the arithmetic result. NaR wins over zero.
module fixed_round_sat #(
    parameter int FX_N = 16
) (
    input  logic            sign,
    input  logic            is_nar,
    input  logic            is_zero,
    input  logic            rnd_mode,
    input  logic            ovf_in,
    input  logic [FX_N+1:0] mag,
    input  logic            guard,
    input  logic            round,
    input  logic            sticky,
    output logic [FX_N:0]   fixed,
    output logic            ovf,
    output logic            nar
);
    import ppu_pkg::*;

    localparam logic [FX_N:0] NAR_VAL = (FX_N+1)'(nar_fixed(FX_N));

    logic            round_up;
    logic [FX_N+2:0] rounded;
    logic            too_big;
    logic [FX_N-1:0] mag_sat;
    logic [FX_N:0]   signed_val;

    always_comb begin
        round_up   = (rnd_mode_e'(rnd_mode) == RND_RNE) && guard && (round || sticky || mag[0]);
        rounded    = {1'b0, mag} + (FX_N+3)'(round_up);
        // The round carry can push a just-fitting magnitude over the limit.
        too_big    = ovf_in || (|rounded[FX_N+2:FX_N]);
        mag_sat    = too_big ? '1 : rounded[FX_N-1:0];
        // Negating a zero magnitude gives zero, so no negative zero can appear.
        signed_val = sign ? -{1'b0, mag_sat} : {1'b0, mag_sat};

        fixed = signed_val;
        ovf   = too_big;
        nar   = 1'b0;
        if (is_nar) begin
            fixed = NAR_VAL;
            ovf   = 1'b0;
            nar   = 1'b1;
        end else if (is_zero) begin
            fixed = '0;
            ovf   = 1'b0;
        end
    end

endmodule

// File: rtl/fir_to_fixed_pipe.sv
// Two-stage pipeline turning a decoded posit {sign, total exponent, mantissa} into
// saturated two's-complement fixed point, with a valid/ready handshake on both sides.
module fir_to_fixed_pipe #(
    parameter int FIR_TE_SIZE   = 8,
    parameter int FIR_FRAC_SIZE = 8,
    parameter int FX_M          = 8,
    parameter int FX_N          = 16,
    parameter int SAT_CNT_W     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [FIR_TE_SIZE+FIR_FRAC_SIZE:0]   fir_i,
    input  logic                                 is_zero_i,
    input  logic                                 is_nar_i,
    input  logic                                 rnd_mode_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [FX_N:0]                        fixed_o,
    output logic                                 ovf_o,
    output logic                                 nar_o,
    input  logic                                 clear_i,
    output logic [SAT_CNT_W-1:0]                 sat_cnt_o
);
    import ppu_pkg::*;

    localparam int GW     = FX_N + 4;
    localparam int LW     = GW + FIR_FRAC_SIZE;
    localparam int S2_OFS = (FX_N - FX_M) - (FIR_FRAC_SIZE - 1) + 2;

    logic                     in_sign;
    logic [FIR_TE_SIZE-1:0]   in_te;
    logic [FIR_FRAC_SIZE-1:0] in_frac;

    assign {in_sign, in_te, in_frac} = fir_i;

    logic signed [31:0]       s2_amt;
    logic signed [31:0]       r_amt;
    logic [LW-1:0]            left_vec;
    logic [FIR_FRAC_SIZE-1:0] sticky_mask;
    logic [GW-1:0]            sh_field;
    logic                     sh_sticky;
    logic                     sh_ovf;

    // s2_amt places the mantissa in a field whose two LSBs are guard and round.
    always_comb begin
        s2_amt      = 32'(signed'(in_te)) + 32'(S2_OFS);
        r_amt       = -s2_amt;
        left_vec    = '0;
        sticky_mask = '0;
        sh_field    = '0;
        sh_sticky   = 1'b0;
        sh_ovf      = 1'b0;
        if (s2_amt >= 0) begin
            if (s2_amt >= LW) begin
                sh_ovf = |in_frac;
            end else begin
                left_vec = LW'(in_frac) << s2_amt;
                sh_field = left_vec[GW-1:0];
                sh_ovf   = |left_vec[LW-1:GW];
            end
        end else if (r_amt >= FIR_FRAC_SIZE) begin
            sh_sticky = |in_frac;
        end else begin
            sh_field    = GW'(in_frac >> r_amt);
            sticky_mask = ~({FIR_FRAC_SIZE{1'b1}} << r_amt);
            sh_sticky   = |(in_frac & sticky_mask);
        end
    end

    logic            s1_valid;
    logic            s1_sign;
    logic            s1_nar;
    logic            s1_zero;
    rnd_mode_e       s1_rnd;
    logic            s1_ovf;
    logic [FX_N+1:0] s1_mag;
    logic            s1_guard;
    logic            s1_round;
    logic            s1_sticky;

    logic            s2_adv;
    logic            accept;

    assign s2_adv  = !valid_o || ready_i;
    assign ready_o = !s1_valid || s2_adv;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_zero   <= 1'b0;
            s1_rnd    <= RND_TRUNC;
            s1_ovf    <= 1'b0;
            s1_mag    <= '0;
            s1_guard  <= 1'b0;
            s1_round  <= 1'b0;
            s1_sticky <= 1'b0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_sign   <= in_sign;
            s1_nar    <= is_nar_i;
            s1_zero   <= is_zero_i;
            s1_rnd    <= rnd_mode_e'(rnd_mode_i);
            s1_ovf    <= sh_ovf;
            s1_mag    <= sh_field[GW-1:2];
            s1_guard  <= sh_field[1];
            s1_round  <= sh_field[0];
            s1_sticky <= sh_sticky;
        end else if (s2_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    logic [FX_N:0] rs_fixed;
    logic          rs_ovf;
    logic          rs_nar;

    fixed_round_sat #(
        .FX_N (FX_N)
    ) u_round_sat (
        .sign     (s1_sign),
        .is_nar   (s1_nar),
        .is_zero  (s1_zero),
        .rnd_mode (s1_rnd),
        .ovf_in   (s1_ovf),
        .mag      (s1_mag),
        .guard    (s1_guard),
        .round    (s1_round),
        .sticky   (s1_sticky),
        .fixed    (rs_fixed),
        .ovf      (rs_ovf),
        .nar      (rs_nar)
    );

    // Result data only changes when a new beat moves in, so a stalled output holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            fixed_o <= '0;
            ovf_o   <= 1'b0;
            nar_o   <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                fixed_o <= rs_fixed;
                ovf_o   <= rs_ovf;
                nar_o   <= rs_nar;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_cnt_o <= '0;
        end else if (clear_i) begin
            sat_cnt_o <= '0;
        end else if (valid_o && ready_i && ovf_o && (sat_cnt_o != '1)) begin
            sat_cnt_o <= sat_cnt_o + SAT_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_to_fixed_pipe.sv
// Scoreboard bench for fir_to_fixed_pipe: directed steps queue expected results,
// a negedge monitor pops and compares each delivered beat.
module tb_fir_to_fixed_pipe;

    localparam int TE  = 8;
    localparam int FR  = 8;
    localparam int FXM = 8;
    localparam int FXN = 16;
    localparam int SCW = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             valid_i;
    logic             ready_o;
    logic [TE+FR:0]   fir_i;
    logic             is_zero_i;
    logic             is_nar_i;
    logic             rnd_mode_i;
    logic             valid_o;
    logic             ready_i;
    logic [FXN:0]     fixed_o;
    logic             ovf_o;
    logic             nar_o;
    logic             clear_i;
    logic [SCW-1:0]   sat_cnt_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [18:0] expQ[$];
    logic        stallSeen = 1'b0;
    logic [19:0] heldOut   = '0;
    logic        accepted;
    logic        drained;
    logic        seenValid;

    logic [7:0]  rTe;
    logic [7:0]  rFrac;
    logic        rSign;
    logic        rZero;
    logic        rNar;
    logic        rRnd;

    fir_to_fixed_pipe #(
        .FIR_TE_SIZE   (TE),
        .FIR_FRAC_SIZE (FR),
        .FX_M          (FXM),
        .FX_N          (FXN),
        .SAT_CNT_W     (SCW)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .fir_i      (fir_i),
        .is_zero_i  (is_zero_i),
        .is_nar_i   (is_nar_i),
        .rnd_mode_i (rnd_mode_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .fixed_o    (fixed_o),
        .ovf_o      (ovf_o),
        .nar_o      (nar_o),
        .clear_i    (clear_i),
        .sat_cnt_o  (sat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Exact arithmetic reference: value = frac * 2^(te + frac_bits - (FR-1)).
    function automatic logic [18:0] modelFixed(input logic sgn, input logic [7:0] te,
                                               input logic [7:0] frac, input logic zero,
                                               input logic nar, input logic rne);
        int          e;
        int          r;
        longint      mag;
        longint      q;
        longint      rem;
        longint      half;
        logic        ovf;
        logic [16:0] res;
        ovf = 1'b0;
        mag = 0;
        e = int'($signed(te)) + (FXN - FXM) - (FR - 1);
        if (nar) return {17'h10000, 2'b01};
        if (zero) return '0;
        if (frac == 0) begin
            mag = 0;
        end else if (e >= 0) begin
            mag = (e >= 20) ? (longint'(1) << 20) : (longint'(frac) << e);
        end else begin
            r = -e;
            if (r >= 20) begin
                mag = 0;
            end else begin
                q    = longint'(frac) >> r;
                rem  = longint'(frac) - (q << r);
                half = longint'(1) << (r - 1);
                mag  = q;
                if (rne && ((rem > half) || ((rem == half) && q[0]))) mag = q + 1;
            end
        end
        if (mag > 65535) begin
            mag = 65535;
            ovf = 1'b1;
        end
        res = sgn ? 17'(131072 - mag) : 17'(mag);
        return {res, ovf, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic sgn, input logic [7:0] te, input logic [7:0] frac,
                                 input logic zero, input logic nar, input logic rne);
        fir_i      = {sgn, te, frac};
        is_zero_i  = zero;
        is_nar_i   = nar;
        rnd_mode_i = rne;
        valid_i    = 1'b1;
        accepted   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                @(posedge clk_i);
                expQ.push_back(modelFixed(sgn, te, frac, zero, nar, rne));
                accepted = 1'b1;
                break;
            end
            @(posedge clk_i);
        end
        if (!accepted) checkOutput("accept_timeout", 32'(ready_o), 32'd1);
        #1;
    endtask

    task automatic idle();
        valid_i   = 1'b0;
        is_zero_i = 1'b0;
        is_nar_i  = 1'b0;
    endtask

    task automatic waitDrain();
        drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (expQ.size() == 0 && !valid_o) begin
                drained = 1'b1;
                break;
            end
        end
        if (!drained) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor: stall stability and in-order scoreboard comparison.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            stallSeen = 1'b0;
        end else begin
            if (stallSeen)
                checkOutput("stall_stable", {12'b0, valid_o, fixed_o, ovf_o, nar_o}, {12'b0, heldOut});
            if (valid_o && ready_i) begin
                if (expQ.size() == 0) checkOutput("unexpected_beat", 32'(valid_o), 32'd0);
                else checkOutput("beat", {13'b0, fixed_o, ovf_o, nar_o}, {13'b0, expQ.pop_front()});
            end
            stallSeen = valid_o && !ready_i;
            heldOut   = {1'b1, fixed_o, ovf_o, nar_o};
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        rst_ni     = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        clear_i    = 1'b0;
        fir_i      = '0;
        is_zero_i  = 1'b0;
        is_nar_i   = 1'b0;
        rnd_mode_i = 1'b1;

        repeat (3) @(posedge clk_i);
        #2;
        checkOutput("rst_valid_o", 32'(valid_o), 32'd0);
        checkOutput("rst_fixed_o", 32'(fixed_o), 32'd0);
        checkOutput("rst_flags", {30'b0, ovf_o, nar_o}, 32'd0);
        checkOutput("rst_sat_cnt", 32'(sat_cnt_o), 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        #1 checkOutput("rst_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        $display("[TB] 1.0 with two-cycle latency");
        applyStimulus(1'b0, 8'd0, 8'h80, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk_i);
        checkOutput("lat_cycle1_valid", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("lat_cycle2_valid", 32'(valid_o), 32'd1);
        checkOutput("one_fixed", 32'(fixed_o), 32'h00100);
        waitDrain();

        $display("[TB] -3.0 and positive saturation");
        applyStimulus(1'b1, 8'd1, 8'hC0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd8, 8'h80, 1'b0, 1'b0, 1'b1);
        idle();
        waitDrain();
        checkOutput("sat_cnt_first", 32'(sat_cnt_o), 32'd1);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
        checkOutput("sat_cnt_cleared", 32'(sat_cnt_o), 32'd0);
        applyStimulus(1'b0, 8'd8, 8'h80, 1'b0, 1'b0, 1'b1);
        idle();
        waitDrain();
        checkOutput("sat_cnt_after_clear", 32'(sat_cnt_o), 32'd1);

        $display("[TB] clear racing an increment");
        ready_i = 1'b0;
        applyStimulus(1'b1, 8'd8, 8'hFF, 1'b0, 1'b0, 1'b0);
        idle();
        seenValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (valid_o) begin
                seenValid = 1'b1;
                break;
            end
        end
        checkOutput("stalled_ovf_valid", 32'(seenValid), 32'd1);
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        checkOutput("sat_cnt_clear_wins", 32'(sat_cnt_o), 32'd0);
        waitDrain();

        $display("[TB] rounding edges and special values");
        applyStimulus(1'b0, 8'hF7, 8'h80, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hF7, 8'h80, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'hF7, 8'hC0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hF7, 8'hC0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hF7, 8'h80, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd2, 8'hA0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'd2, 8'hA0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'd0, 8'h80, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'd7, 8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hFC, 8'hB8, 1'b0, 1'b0, 1'b1);
        idle();
        waitDrain();

        $display("[TB] back-to-back beats against a stalled sink");
        ready_i = 1'b0;
        fork
            begin
                applyStimulus(1'b0, 8'd3, 8'h90, 1'b0, 1'b0, 1'b1);
                applyStimulus(1'b1, 8'd4, 8'hA8, 1'b0, 1'b0, 1'b1);
                applyStimulus(1'b0, 8'd9, 8'hC0, 1'b0, 1'b0, 1'b0);
                applyStimulus(1'b1, 8'hFE, 8'hE4, 1'b0, 1'b0, 1'b1);
                idle();
            end
            begin
                @(posedge clk_i);
                @(posedge clk_i);
                #2 checkOutput("ready_o_stalled", 32'(ready_o), 32'd0);
                @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] random beats with random backpressure");
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    rSign = 1'($urandom_range(0, 1));
                    rTe   = 8'($urandom_range(0, 40)) - 8'd24;
                    rFrac = {1'b1, 7'($urandom_range(0, 127))};
                    if ($urandom_range(0, 9) == 0) rFrac = 8'h00;
                    rZero = ($urandom_range(0, 15) == 0);
                    rNar  = ($urandom_range(0, 15) == 0);
                    rRnd  = 1'($urandom_range(0, 1));
                    applyStimulus(rSign, rTe, rFrac, rZero, rNar, rRnd);
                end
                idle();
            end
            begin
                repeat (60) begin
                    @(posedge clk_i);
                    #1 ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        ready_i = 1'b1;
        waitDrain();

        $display("[TB] reset with beats in flight");
        ready_i = 1'b0;
        applyStimulus(1'b0, 8'd1, 8'hC0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'd2, 8'h80, 1'b0, 1'b0, 1'b1);
        idle();
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("midrst_valid_o", 32'(valid_o), 32'd0);
        checkOutput("midrst_ready_o", 32'(ready_o), 32'd1);
        checkOutput("midrst_fixed_o", 32'(fixed_o), 32'd0);
        expQ.delete();
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("no_stale_beat", 32'(valid_o), 32'd0);
        end
        @(posedge clk_i);
        #1;
        applyStimulus(1'b0, 8'd1, 8'h80, 1'b0, 1'b0, 1'b1);
        idle();
        @(negedge clk_i);
        checkOutput("post_rst_lat1", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        checkOutput("post_rst_lat2", 32'(valid_o), 32'd1);
        waitDrain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
